// File: rtl/airflow_ctrl.sv
// -----------------------------------------------------------------------------
// airflow_ctrl -- oxygen supply / vent controller
//
// Tracks a shared oxygen reserve that drains by DRAIN units per open vent per
// cycle and can be topped up by REFILL units per cycle. A four-state FSM
// (OFF / NORM / LOW / DEPL) raises a low-oxygen alert with hysteresis and
// closes every vent once the reserve is exhausted.
//
// Optional feature: define AIRFLOW_SHED_EN to make the controller shed load
// while in LOW by closing the highest-index open vent on every cycle.
//
// Ports:
//   clk            in   clock
//   rst            in   asynchronous active-high reset
//   en             in   component enable (0 forces OFF)
//   refill         in   add REFILL to the reserve this cycle
//   vent_wr_valid  in   vent write request
//   vent_wr_idx    in   room index of the write
//   vent_wr_val    in   1 = open the vent, 0 = close it
//   vent_wr_ready  out  write accepted when valid & ready (0 in OFF)
//   vent_wr_err    out  one-cycle pulse after a bad index or a refused open
//   oxygen         out  current oxygen level
//   vents          out  vent open mask, bit i = room i
//   alert          out  registered low-oxygen flag (state LOW or DEPL)
//   state          out  registered FSM state
// -----------------------------------------------------------------------------
module airflow_ctrl #(
  parameter int ROOMS      = 4,
  parameter int OW         = 8,
  parameter int O2_INIT    = 198,
  parameter int DRAIN      = 5,
  parameter int REFILL     = 3,
  parameter int LOW_THRESH = 50,
  parameter int HYST       = 10,
  localparam int IW        = (ROOMS > 1) ? $clog2(ROOMS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             refill,
  input  logic             vent_wr_valid,
  input  logic [IW-1:0]    vent_wr_idx,
  input  logic             vent_wr_val,
  output logic             vent_wr_ready,
  output logic             vent_wr_err,
  output logic [OW-1:0]    oxygen,
  output logic [ROOMS-1:0] vents,
  output logic             alert,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_OFF  = 2'b00,
    S_NORM = 2'b01,
    S_LOW  = 2'b10,
    S_DEPL = 2'b11
  } state_e;

  // Saturation ceiling of the oxygen register, held in the 32-bit working width.
  localparam logic [31:0] O_MAX = 32'((64'd1 << OW) - 64'd1);

  state_e           state_q, state_d;
  logic [OW-1:0]    oxy_q, oxy_d;
  logic [ROOMS-1:0] vents_q, vents_d;
  logic             alert_q, alert_d;
  logic             err_q, err_d;

  // Datapath: next oxygen level o' and write decode
  logic [31:0] pop_w, add_w, sub_w, o_next_w;
  logic        wr_fire, idx_ok, wr_reject, wr_apply, wr_err;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    pop_w = '0;
    for (int i = 0; i < ROOMS; i++) begin
      pop_w = pop_w + 32'(vents_q[i]);
    end
    // 32-bit working width leaves ample headroom, so neither sum wraps.
    add_w = 32'(oxy_q) + (refill ? 32'(REFILL) : 32'd0);
    sub_w = 32'(DRAIN) * pop_w;
    if (sub_w >= add_w) begin
      o_next_w = '0;
    end else if ((add_w - sub_w) > O_MAX) begin
      o_next_w = O_MAX;
    end else begin
      o_next_w = add_w - sub_w;
    end
  end

  assign vent_wr_ready = (state_q != S_OFF);
  assign wr_fire       = vent_wr_valid & vent_wr_ready;
  assign idx_ok        = (32'(vent_wr_idx) < 32'(ROOMS));
  // Opening a vent is refused once the reserve is low or gone.
  assign wr_reject     = wr_fire & vent_wr_val &
                         ((state_q == S_LOW) | (state_q == S_DEPL));
  assign wr_apply      = wr_fire & idx_ok & ~wr_reject;
  assign wr_err        = wr_fire & (~idx_ok | wr_reject);

  // Process 1: state and output registers
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: reset is asynchronous, so outputs take their idle values the
    // moment rst rises; an in-flight write is dropped with no error pulse.
    if (rst) begin
      state_q <= S_OFF;
      oxy_q   <= OW'(O2_INIT);
      vents_q <= '1;
      alert_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed by the combinational processes.
      state_q <= state_d;
      oxy_q   <= oxy_d;
      vents_q <= vents_d;
      alert_q <= alert_d;
      err_q   <= err_d;
    end
  end

  // Process 2: next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_OFF:  state_d = en ? S_NORM : S_OFF;
      S_NORM: begin
        if (o_next_w == '0)                          state_d = S_DEPL;
        else if (o_next_w <= 32'(LOW_THRESH))        state_d = S_LOW;
        else                                         state_d = S_NORM;
      end
      S_LOW: begin
        if (o_next_w == '0)                          state_d = S_DEPL;
        else if (o_next_w > 32'(LOW_THRESH + HYST))  state_d = S_NORM;
        else                                         state_d = S_LOW;
      end
      S_DEPL: state_d = (o_next_w != '0) ? S_LOW : S_DEPL;
      default: state_d = S_OFF;
    endcase
    // Disable wins over every level-driven transition.
    if (state_q != S_OFF && !en) begin
      state_d = S_OFF;
    end
  end

  // Process 3: next values of the registered outputs
`ifdef AIRFLOW_SHED_EN
  logic [ROOMS-1:0] shed_mask;
  always_comb begin
    // The last set bit found in ascending order is the highest-index one.
    shed_mask = '1;
    for (int i = 0; i < ROOMS; i++) begin
      if (vents_q[i]) begin
        shed_mask    = '1;
        shed_mask[i] = 1'b0;
      end
    end
  end
`endif

  always_comb begin
    oxy_d   = oxy_q;
    vents_d = vents_q;
    alert_d = 1'b0;
    err_d   = 1'b0;
    if (state_q == S_OFF) begin
      // Idle: hold the reload values; refill is ignored.
      oxy_d   = OW'(O2_INIT);
      vents_d = '1;
    end else begin
      oxy_d = o_next_w[OW-1:0];
      for (int i = 0; i < ROOMS; i++) begin
        if (wr_apply && 32'(vent_wr_idx) == i) begin
          vents_d[i] = vent_wr_val;
        end
      end
`ifdef AIRFLOW_SHED_EN
      // A close-write and shedding both clear bits, so they simply combine.
      if (state_q == S_LOW) begin
        vents_d = vents_d & shed_mask;
      end
`endif
      // Depletion overrides writes and shedding.
      if (state_d == S_DEPL) begin
        vents_d = '0;
      end
      err_d = wr_err;
    end
    alert_d = (state_d == S_LOW) || (state_d == S_DEPL);
  end

  assign state       = state_q;
  assign oxygen      = oxy_q;
  assign vents       = vents_q;
  assign alert       = alert_q;
  assign vent_wr_err = err_q;

endmodule
